// File: rtl/tlc_param.sv
// Parametrised two-road traffic light controller: main road with left-turn arrow,
// side road with pedestrian walk, night flashing mode. Moore outputs, registered.
module tlc_param #(
  parameter int TW         = 8,
  parameter int MIN_GREEN  = 6,
  parameter int YELLOW     = 2,
  parameter int ARROW      = 3,
  parameter int SIDE_GREEN = 4,
  parameter int ALL_RED    = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       SD,
  input  logic       MD,
  input  logic       PB,
  input  logic       FLASH,
  output logic       MR,
  output logic       MY,
  output logic       MG,
  output logic       MA,
  output logic       SR,
  output logic       SY,
  output logic       SG,
  output logic       WALK,
  output logic [3:0] STATE
);

  localparam int TMAX = (1 << TW) - 1;

  if (MIN_GREEN < 1 || MIN_GREEN > TMAX || YELLOW < 1 || YELLOW > TMAX ||
      ARROW < 1 || ARROW > TMAX || SIDE_GREEN < 1 || SIDE_GREEN > TMAX ||
      ALL_RED < 1 || ALL_RED > TMAX) begin : g_bad_param
    $error("tlc_param: every duration parameter must be in 1..2^TW-1");
  end

  // A phase of duration D ends on the edge where the dwell timer reads D-1.
  localparam logic [TW-1:0] MG_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] Y_LAST  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] A_LAST  = TW'(ARROW - 1);
  localparam logic [TW-1:0] SG_LAST = TW'(SIDE_GREEN - 1);
  localparam logic [TW-1:0] AR_LAST = TW'(ALL_RED - 1);

  typedef enum logic [3:0] {
    S_MAIN_GREEN  = 4'd0,
    S_MAIN_YELLOW = 4'd1,
    S_ARROW       = 4'd2,
    S_SIDE_GREEN  = 4'd3,
    S_SIDE_YELLOW = 4'd4,
    S_ALL_RED     = 4'd5,
    S_FLASHING    = 4'd8
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr;
  logic            sd_req, md_req, pb_req;
  logic            walk_act, walk_nxt;
  logic            blink, blink_nxt;
  logic [7:0]      lamp_q, lamp_nxt;
  logic            enter_s2, enter_s3, side_busy;

  always_comb begin
    state_nxt = state;
    case (state)
      S_MAIN_GREEN: begin
        if (FLASH)
          state_nxt = S_FLASHING;
        else if (tmr >= MG_LAST && (sd_req || md_req || pb_req))
          state_nxt = S_MAIN_YELLOW;
      end
      S_MAIN_YELLOW: if (tmr == Y_LAST)  state_nxt = md_req ? S_ARROW : S_SIDE_GREEN;
      S_ARROW:       if (tmr == A_LAST)  state_nxt = (sd_req || pb_req) ? S_SIDE_GREEN : S_MAIN_GREEN;
      S_SIDE_GREEN:  if (tmr == SG_LAST) state_nxt = S_SIDE_YELLOW;
      S_SIDE_YELLOW: if (tmr == Y_LAST)  state_nxt = S_ALL_RED;
      S_ALL_RED:     if (tmr == AR_LAST) state_nxt = S_MAIN_GREEN;
      S_FLASHING:    if (!FLASH)         state_nxt = S_ALL_RED;
      default:       state_nxt = S_MAIN_GREEN;
    endcase
  end

  assign enter_s2  = (state_nxt == S_ARROW) && (state != S_ARROW);
  assign enter_s3  = (state_nxt == S_SIDE_GREEN) && (state != S_SIDE_GREEN);
  assign side_busy = (state == S_SIDE_GREEN) || (state == S_SIDE_YELLOW);

  // Walk and blink are computed ahead so the lamp register lines up with the state register.
  always_comb begin
    walk_nxt = walk_act;
    if (enter_s3)
      walk_nxt = pb_req;
    else if (state_nxt != S_SIDE_GREEN)
      walk_nxt = 1'b0;

    blink_nxt = 1'b0;
    if (state_nxt == S_FLASHING)
      blink_nxt = (state == S_FLASHING) ? ~blink : 1'b1;
  end

  // Lamp order: MR MY MG MA SR SY SG WALK
  always_comb begin
    lamp_nxt = 8'b0000_0000;
    case (state_nxt)
      S_MAIN_GREEN:  lamp_nxt = 8'b0010_1000;
      S_MAIN_YELLOW: lamp_nxt = 8'b0100_1000;
      S_ARROW:       lamp_nxt = 8'b1001_1000;
      S_SIDE_GREEN:  lamp_nxt = {7'b1000_001, walk_nxt};
      S_SIDE_YELLOW: lamp_nxt = 8'b1000_0100;
      S_ALL_RED:     lamp_nxt = 8'b1000_1000;
      S_FLASHING:    lamp_nxt = {1'b0, blink_nxt, 2'b00, blink_nxt, 3'b000};
      default:       lamp_nxt = 8'b1000_1000;
    endcase
  end

  // A clear on entering the serving phase wins over a same-edge request.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_MAIN_GREEN;
      tmr      <= '0;
      sd_req   <= 1'b0;
      md_req   <= 1'b0;
      pb_req   <= 1'b0;
      walk_act <= 1'b0;
      blink    <= 1'b0;
      lamp_q   <= 8'b0010_1000;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        tmr <= '0;
      else if (tmr != '1)
        tmr <= tmr + TW'(1);

      if (enter_s3)
        sd_req <= 1'b0;
      else if (SD && !side_busy)
        sd_req <= 1'b1;

      if (enter_s3)
        pb_req <= 1'b0;
      else if (PB && !side_busy)
        pb_req <= 1'b1;

      if (enter_s2)
        md_req <= 1'b0;
      else if (MD && state != S_ARROW)
        md_req <= 1'b1;

      walk_act <= walk_nxt;
      blink    <= blink_nxt;
      lamp_q   <= lamp_nxt;
    end
  end

  assign {MR, MY, MG, MA, SR, SY, SG, WALK} = lamp_q;
  assign STATE = state;

endmodule

// File: doc/tlc_param.md
# tlc_param

Parametrised two-road traffic light controller: main road with a protected left-turn arrow, side road with a pedestrian walk signal, plus a night flashing mode. It generalises the fixed-timing controller. Phase durations come from parameters, demand requests are latched, and phases run off a shared dwell timer. It is a Moore machine driving the lamp outputs and a 4-bit state code for monitoring and for lock-step comparison against a reference model.

## Interface
- TW, 8: dwell timer width; every duration parameter must be in 1..2^TW-1 (elaboration-time check)
- MIN_GREEN, 6: minimum main-green cycles before a request is honoured
- YELLOW, 2: cycles in each yellow phase
- ARROW, 3: cycles of main left-turn arrow
- SIDE_GREEN, 4: cycles of side green (and walk)
- ALL_RED, 1: all-red clearance cycles

Ports:
- clk  in  1  single clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- SD  in  1  side-road car present (level)
- MD  in  1  main left-turn car present (level)
- PB  in  1  pedestrian button (level or pulse)
- FLASH  in  1  night flashing mode request (level)
- MR, MY, MG, MA  out  1 each  main red / yellow / green / left arrow
- SR, SY, SG  out  1 each  side red / yellow / green
- WALK  out  1  pedestrian walk lamp
- STATE  out  4  current state code

## Operation
- States and codes:
  - S0 MAIN_GREEN=0: MG, SR
  - S1 MAIN_YELLOW=1: MY, SR
  - S2 ARROW=2: MR, MA, SR
  - S3 SIDE_GREEN=3: MR, SG, WALK if walk_act
  - S4 SIDE_YELLOW=4: MR, SY
  - S5 ALL_RED=5: MR, SR
  - S8 FLASHING=8: MY=SR=blink, all other lamps 0
- Outputs decode from the state register only (Moore). No lamp combination other than the ones listed is ever produced.
- Request latches sd_req, md_req, pb_req:
  - Each is set by its input being high at a clock edge.
  - SD and PB are ignored while in S3/S4. MD is ignored while in S2.
  - sd_req and pb_req clear on the edge entering S3. md_req clears on the edge entering S2.
  - Latches hold through S8.
- walk_act is loaded with pb_req on the edge entering S3 and cleared on leaving S3.
- Dwell timer tmr: zeroed on every state change, otherwise increments, saturating at 2^TW-1. A phase of duration D ends at the edge where tmr==D-1.
- Transitions, evaluated at each clk edge:
  - S0: FLASH=1 -> S8, taking priority over everything. Else if tmr>=MIN_GREEN-1 and any request is latched -> S1. Else stay.
  - S1 done: md_req -> S2, else -> S3.
  - S2 done: sd_req|pb_req -> S3, else -> S0.
  - S3 done -> S4. S4 done -> S5. S5 done -> S0.
  - S8: blink starts at 1 on entry and toggles every cycle. FLASH=0 -> S5.
  - FLASH is sampled only in S0 and S8.

## Timing
- Reset (async, no clock needed): STATE=0, MG=1, SR=1, all other outputs 0, tmr=0, all latches and walk_act cleared, blink=0.
- Releasing clr mid-phase takes effect immediately. The next edge counts as S0 cycle 1.
- Input-to-request latency is 1 edge. The earliest lamp change is at the edge where the S0 minimum is met.
- State residency, in edges:
  - S0 ≥ MIN_GREEN
  - S1 and S4 = YELLOW
  - S2 = ARROW
  - S3 = SIDE_GREEN
  - S5 = ALL_RED
  - S8 is unbounded
- Simultaneous MD, SD and PB produce the single cycle S1->S2->S3->S4->S5->S0. The arrow is always served before the side road.
- A request arriving on the same edge as the clearing transition: the clear wins for that edge. A still-asserted input re-sets the latch on the next permitted edge.

## Test plan
- Reset, no requests for 30 cycles -> STATE=0, MG=SR=1 throughout; WALK, MA and SG never 1.
- One-cycle SD pulse at cycle 2 -> S0 for 6 cycles total, then STATE 1×2, 3×4 (WALK=0), 4×2, 5×1, then 0. SD held high during S3 causes no repeat request.
- MD only, held -> 0 (6 cycles) ->1×2 ->2×3 with MR=MA=SR=1 ->0. S3 is never entered.
- MD, SD and PB together -> 0→1→2→3→4→5→0 with durations 6,2,3,4,2,1. WALK=1 for all 4 cycles of S3. A PB press during S3 is ignored.
- FLASH=1 while in S0 -> STATE=8 at the next edge, MY=SR toggling 1,0,1,… An SD pulse during flash is retained. FLASH=0 -> STATE 5 for 1 cycle, then 0. The side road is served after 6 cycles of S0.
- clr asserted mid-S3 with WALK=1 -> immediately, with no clock edge: STATE=0, MG=SR=1, WALK=0. After release, no stale request is served.
